multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Multi-cycle controller that sequences the 9-bit-ISA datapath (pc, reg_file, ALU, data memory) through fetch/decode/execute/memory/writeback. Owns the program counter and instruction register, handshakes with instruction and data memories that may insert wait states, and drives the per-cycle enables the datapath consumes. Sits between the memories and the datapath in the processor top level, replacing purely combinational control.

## Interface
- START_PC, 0, PC value loaded on start
- PC_W, 10, program counter width
- CNT_W, 16, retired-instruction counter width

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin execution; honoured only in IDLE or HALT
- imem_addr  out  PC_W  current pc
- imem_req  out  1  fetch request, high throughout FETCH
- imem_valid  in  1  instruction data valid this cycle
- imem_data  in  9  instruction word {opcode[8:6], rd[5:3], rs[2:0]}, addr = [5:0]
- opcode  out  3  IR[8:6]
- rd  out  3  IR[5:3] for ALU ops, 3'b000 otherwise
- rs  out  3  IR[2:0] for ALU ops, 3'b000 otherwise
- addr  out  6  IR[5:0]
- two_reg  out  1  high in EXEC of ALU ops
- reg_we  out  1  register write strobe, high only in WB
- reg_wsel  out  1  1 = write data from memory, 0 = from ALU
- dmem_re  out  1  load strobe, high throughout MEM of LOAD
- dmem_we  out  1  store strobe, high throughout MEM of STORE
- dmem_ready  in  1  data memory completes access this cycle
- busy  out  1  state not IDLE/HALT
- done  out  1  high in HALT
- instr_count  out  CNT_W  retired instructions since start

## Operation
- Opcodes: 0-4 ALU (rd <= rd op rs); 5 LOAD (r0 <= mem[addr]); 6 STORE (mem[addr] <= r0); 7 JUMP (pc <= zero-extended addr).
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: all strobes low; start -> pc <= START_PC, instr_count <= 0, go FETCH.
- FETCH: imem_req=1, imem_addr=pc; on imem_valid, IR <= imem_data, go DECODE; otherwise hold (unbounded wait).
- DECODE: one cycle; opcode/rd/rs/addr valid from IR. ALU/JUMP -> EXEC; LOAD/STORE -> MEM.
- EXEC (ALU): two_reg=1, go WB.
- EXEC (JUMP): if {PC_W-6 zeros, addr} == pc (self-jump) -> HALT, count incremented; else pc <= addr, count incremented, go FETCH.
- MEM: dmem_re (LOAD) or dmem_we (STORE) held high until dmem_ready sampled high. LOAD -> WB; STORE -> retire (pc+1, count+1), go FETCH.
- WB: reg_we=1, reg_wsel=1 for LOAD else 0; retire (pc+1, count+1), go FETCH.
- HALT: done=1, pc and count frozen; start restarts exactly as from IDLE.
- pc increment wraps modulo 2^PC_W (max -> 0). instr_count saturates at all-ones.
- Ignored inputs: start while busy, imem_valid outside FETCH, dmem_ready outside MEM.

## Timing
- Reset values: state IDLE, pc = START_PC, IR = 0, instr_count = 0; all strobes, busy, done = 0; opcode/rd/rs/addr = 0.
- Reset has priority over every other event, including mid-FETCH or mid-MEM; strobes low the cycle after reset is sampled.
- All outputs are registered state or decode of registered state; no combinational path from any input to any output.
- Zero-wait latencies (imem_valid and dmem_ready high in first cycle): ALU 4 cycles (FETCH, DECODE, EXEC, WB); LOAD 4 (FETCH, DECODE, MEM, WB); STORE 3; JUMP 3.
- Each imem/dmem wait cycle adds exactly one cycle; strobes and imem_addr stable during waits.
- Retirement (pc update, instr_count update) occurs on the edge leaving the final state of the instruction.
- busy rises the cycle after start accepted; done rises the cycle after EXEC of a self-jump.

## Test plan
- Reset then start at START_PC=0, ALU op 9'b000_001_010 with zero-wait imem -> reg_we high in cycle 4 with reg_wsel=0, rd=1, rs=2; pc=1, instr_count=1.
- LOAD addr 6'h2A with dmem_ready delayed 3 cycles -> dmem_re high 4 cycles, rd=0, WB reg_wsel=1; instruction completes in 7 cycles.
- STORE addr 6'h05 with zero-wait -> dmem_we high one cycle, reg_we never high, pc+1 after 3 cycles.
- JUMP to 6'h10 from pc=3 -> pc=0x010 next FETCH; later JUMP 6'h10 at pc=0x010 -> done=1, busy=0, pc frozen; start restarts from 0 with count 0.
- pc=0x3FF ALU op -> pc wraps to 0x000; imem_valid held low 5 cycles in FETCH -> imem_req held, no state change.
- Assert reset during MEM of LOAD -> next cycle IDLE, all strobes 0, pc=START_PC, instr_count=0; start pulsed while busy -> no effect.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle controller for the 9-bit-ISA datapath: owns pc, IR and the retired-instruction
// count, handshakes with wait-state memories and drives registered per-cycle datapath strobes.
module multicycle_sequencer #(
  parameter int unsigned START_PC = 0,
  parameter int unsigned PC_W     = 10,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [PC_W-1:0]  imem_addr,
  output logic             imem_req,
  input  logic             imem_valid,
  input  logic [8:0]       imem_data,
  output logic [2:0]       opcode,
  output logic [2:0]       rd,
  output logic [2:0]       rs,
  output logic [5:0]       addr,
  output logic             two_reg,
  output logic             reg_we,
  output logic             reg_wsel,
  output logic             dmem_re,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  localparam logic [2:0]      OpLoad  = 3'd5;
  localparam logic [2:0]      OpStore = 3'd6;
  localparam logic [2:0]      OpJump  = 3'd7;
  localparam logic [PC_W-1:0] StartPc = PC_W'(START_PC);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [8:0]       ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             imem_req_q, two_reg_q, reg_we_q, reg_wsel_q, dmem_re_q, dmem_we_q;
  logic             busy_q, done_q;

  logic [2:0]       ir_op;
  logic             ir_alu;
  logic [PC_W-1:0]  jump_target;
  logic [PC_W-1:0]  pc_inc;
  logic [CNT_W-1:0] cnt_inc;

  assign ir_op       = ir_q[8:6];
  assign ir_alu      = (ir_op < OpLoad);
  assign jump_target = PC_W'(ir_q[5:0]);
  assign pc_inc      = pc_q + 1'b1;
  // Count sticks at all-ones rather than wrapping.
  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          pc_d    = StartPc;
          cnt_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (imem_valid) begin
          ir_d    = imem_data;
          state_d = StDecode;
        end
      end
      StDecode: begin
        state_d = (ir_op == OpLoad || ir_op == OpStore) ? StMem : StExec;
      end
      StExec: begin
        if (ir_op == OpJump) begin
          cnt_d = cnt_inc;
          // A jump to its own address is the program's halt idiom.
          if (jump_target == pc_q) begin
            state_d = StHalt;
          end else begin
            pc_d    = jump_target;
            state_d = StFetch;
          end
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (dmem_ready) begin
          if (ir_op == OpLoad) begin
            state_d = StWb;
          end else begin
            pc_d    = pc_inc;
            cnt_d   = cnt_inc;
            state_d = StFetch;
          end
        end
      end
      StWb: begin
        pc_d    = pc_inc;
        cnt_d   = cnt_inc;
        state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state they describe.
  logic [2:0] op_d;
  assign op_d = ir_d[8:6];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= StartPc;
      ir_q       <= '0;
      cnt_q      <= '0;
      imem_req_q <= 1'b0;
      two_reg_q  <= 1'b0;
      reg_we_q   <= 1'b0;
      reg_wsel_q <= 1'b0;
      dmem_re_q  <= 1'b0;
      dmem_we_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      cnt_q      <= cnt_d;
      imem_req_q <= (state_d == StFetch);
      two_reg_q  <= (state_d == StExec) && (op_d < OpLoad);
      reg_we_q   <= (state_d == StWb);
      reg_wsel_q <= (state_d == StWb) && (op_d == OpLoad);
      dmem_re_q  <= (state_d == StMem) && (op_d == OpLoad);
      dmem_we_q  <= (state_d == StMem) && (op_d == OpStore);
      busy_q     <= (state_d != StIdle) && (state_d != StHalt);
      done_q     <= (state_d == StHalt);
    end
  end

  assign imem_addr   = pc_q;
  assign imem_req    = imem_req_q;
  assign opcode      = ir_op;
  assign rd          = ir_alu ? ir_q[5:3] : 3'b000;
  assign rs          = ir_alu ? ir_q[2:0] : 3'b000;
  assign addr        = ir_q[5:0];
  assign two_reg     = two_reg_q;
  assign reg_we      = reg_we_q;
  assign reg_wsel    = reg_wsel_q;
  assign dmem_re     = dmem_re_q;
  assign dmem_we     = dmem_we_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: per-instruction transaction model predicts every cycle's outputs.
module tb_multicycle_sequencer;

  localparam logic [9:0] START_PC = 10'd0;

  logic        clk = 1'b0;
  logic        reset, start, imem_valid, dmem_ready;
  logic [8:0]  imem_data;
  logic [9:0]  imem_addr;
  logic        imem_req, two_reg, reg_we, reg_wsel, dmem_re, dmem_we, busy, done;
  logic [2:0]  opcode, rd, rs;
  logic [5:0]  addr;
  logic [15:0] instr_count;

  always #5 clk = ~clk;

  multicycle_sequencer #(
    .START_PC(0),
    .PC_W    (10),
    .CNT_W   (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .opcode     (opcode),
    .rd         (rd),
    .rs         (rs),
    .addr       (addr),
    .two_reg    (two_reg),
    .reg_we     (reg_we),
    .reg_wsel   (reg_wsel),
    .dmem_re    (dmem_re),
    .dmem_we    (dmem_we),
    .dmem_ready (dmem_ready),
    .busy       (busy),
    .done       (done),
    .instr_count(instr_count)
  );

  typedef struct packed {
    logic [9:0]  imem_addr;
    logic        imem_req;
    logic [2:0]  opcode;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [5:0]  addr;
    logic        two_reg;
    logic        reg_we;
    logic        reg_wsel;
    logic        dmem_re;
    logic        dmem_we;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
  } obs_t;

  obs_t obs, exp_q;
  logic chk_en = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc_n = 0;

  assign obs = {imem_addr, imem_req, opcode, rd, rs, addr, two_reg, reg_we, reg_wsel,
                dmem_re, dmem_we, busy, done, instr_count};

  // Architectural model: pc, IR, count and halted flag, advanced per instruction.
  logic [9:0]  m_pc;
  logic [8:0]  m_ir;
  logic [15:0] m_cnt;
  logic        m_halted;

  // Per-instruction observations of the DUT for literal checks.
  int          re_cyc, we_cyc, rwe_cyc;
  logic [2:0]  wb_rd, wb_rs;
  logic        wb_wsel;

  always @(negedge clk) begin
    cyc_n++;
    if (chk_en) begin
      n_checks++;
      if (obs === exp_q) n_pass++;
      else $display("FAIL cycle %0d outputs: got %h required %h", cyc_n, obs, exp_q);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  function automatic obs_t mk(input logic req, input logic two, input logic we, input logic wsel,
                              input logic re, input logic dwe, input logic bsy, input logic dn);
    obs_t o;
    logic alu;
    alu        = (m_ir[8:6] < 3'd5);
    o.imem_addr = m_pc;
    o.imem_req  = req;
    o.opcode    = m_ir[8:6];
    o.rd        = alu ? m_ir[5:3] : 3'b000;
    o.rs        = alu ? m_ir[2:0] : 3'b000;
    o.addr      = m_ir[5:0];
    o.two_reg   = two;
    o.reg_we    = we;
    o.reg_wsel  = wsel;
    o.dmem_re   = re;
    o.dmem_we   = dwe;
    o.busy      = bsy;
    o.done      = dn;
    o.cnt       = m_cnt;
    return o;
  endfunction

  // Called at posedge+1: e describes the current cycle; inputs apply to the next edge.
  task automatic drive(input obs_t e, input logic rst, input logic st, input logic iv,
                       input logic [8:0] d, input logic dr);
    if (dmem_re) re_cyc++;
    if (dmem_we) we_cyc++;
    if (reg_we) begin
      rwe_cyc++;
      wb_rd   = rd;
      wb_rs   = rs;
      wb_wsel = reg_wsel;
    end
    exp_q      = e;
    chk_en     = 1'b1;
    reset      = rst;
    start      = st;
    imem_valid = iv;
    imem_data  = d;
    dmem_ready = dr;
    @(posedge clk);
    #1;
  endtask

  task automatic retire();
    m_pc  = m_pc + 10'd1;
    m_cnt = sat_inc(m_cnt);
  endtask

  task automatic idle_cycle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, m_halted), 0, 0, rb(), 9'($urandom), rb());
  endtask

  task automatic do_start();
    drive(mk(0, 0, 0, 0, 0, 0, 0, m_halted), 0, 1, rb(), 9'($urandom), rb());
    m_pc     = START_PC;
    m_cnt    = 16'd0;
    m_halted = 1'b0;
  endtask

  task automatic fetch_decode(input logic [8:0] w, input int fw);
    for (int i = 0; i < fw; i++)
      drive(mk(1, 0, 0, 0, 0, 0, 1, 0), 0, rb(), 0, 9'($urandom), rb());
    drive(mk(1, 0, 0, 0, 0, 0, 1, 0), 0, rb(), 1, w, rb());
    m_ir = w;
    drive(mk(0, 0, 0, 0, 0, 0, 1, 0), 0, rb(), rb(), 9'($urandom), rb());
  endtask

  task automatic run_instr(input logic [8:0] w, input int fw, input int mw);
    logic [2:0] op;
    op      = w[8:6];
    re_cyc  = 0;
    we_cyc  = 0;
    rwe_cyc = 0;
    fetch_decode(w, fw);
    if (op < 3'd5) begin
      drive(mk(0, 1, 0, 0, 0, 0, 1, 0), 0, rb(), rb(), 9'($urandom), rb());
      drive(mk(0, 0, 1, 0, 0, 0, 1, 0), 0, rb(), rb(), 9'($urandom), rb());
      retire();
    end else if (op == 3'd5) begin
      for (int i = 0; i < mw; i++)
        drive(mk(0, 0, 0, 0, 1, 0, 1, 0), 0, rb(), rb(), 9'($urandom), 0);
      drive(mk(0, 0, 0, 0, 1, 0, 1, 0), 0, rb(), rb(), 9'($urandom), 1);
      drive(mk(0, 0, 1, 1, 0, 0, 1, 0), 0, rb(), rb(), 9'($urandom), rb());
      retire();
    end else if (op == 3'd6) begin
      for (int i = 0; i < mw; i++)
        drive(mk(0, 0, 0, 0, 0, 1, 1, 0), 0, rb(), rb(), 9'($urandom), 0);
      drive(mk(0, 0, 0, 0, 0, 1, 1, 0), 0, rb(), rb(), 9'($urandom), 1);
      retire();
    end else begin
      drive(mk(0, 0, 0, 0, 0, 0, 1, 0), 0, rb(), rb(), 9'($urandom), rb());
      m_cnt = sat_inc(m_cnt);
      if (10'(w[5:0]) == m_pc) m_halted = 1'b1;
      else m_pc = 10'(w[5:0]);
    end
  endtask

  initial begin
    logic [8:0] w;
    logic [9:0] pre;
    logic       wrapped;
    int         guard;

    reset      = 1'b1;
    start      = 1'b0;
    imem_valid = 1'b0;
    imem_data  = '0;
    dmem_ready = 1'b0;
    m_pc       = START_PC;
    m_ir       = '0;
    m_cnt      = '0;
    m_halted   = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset imem_req", imem_req, 0);
    check("reset imem_addr", imem_addr, 0);
    check("reset instr_count", instr_count, 0);
    idle_cycle();
    idle_cycle();

    do_start();
    check("busy after start", busy, 1);
    run_instr(9'b000_001_010, 0, 0);
    check("alu wb rd", wb_rd, 1);
    check("alu wb rs", wb_rs, 2);
    check("alu wb reg_wsel", wb_wsel, 0);
    check("alu reg_we cycles", rwe_cyc, 1);
    check("alu pc", imem_addr, 1);
    check("alu instr_count", instr_count, 1);

    run_instr(9'b101_101010, 0, 3);
    check("load dmem_re cycles", re_cyc, 4);
    check("load wb reg_wsel", wb_wsel, 1);
    check("load wb rd", wb_rd, 0);
    check("load pc", imem_addr, 2);

    run_instr(9'b110_000101, 0, 0);
    check("store dmem_we cycles", we_cyc, 1);
    check("store reg_we cycles", rwe_cyc, 0);
    check("store pc", imem_addr, 3);

    run_instr(9'b111_010000, 0, 0);
    check("jump pc", imem_addr, 10'h010);
    check("jump imem_req", imem_req, 1);
    run_instr(9'b111_010000, 0, 0);
    check("halt done", done, 1);
    check("halt busy", busy, 0);
    check("halt pc", imem_addr, 10'h010);
    check("halt instr_count", instr_count, 5);
    idle_cycle();
    idle_cycle();
    do_start();
    check("restart pc", imem_addr, 0);
    check("restart instr_count", instr_count, 0);

    run_instr(9'b011_100_111, 5, 0);
    check("fetch wait instr_count", instr_count, 1);

    // Reset in the middle of a stalled LOAD, with dmem_ready asserted in the same cycle.
    fetch_decode(9'b101_000011, 0);
    drive(mk(0, 0, 0, 0, 1, 0, 1, 0), 0, rb(), rb(), 9'($urandom), 0);
    drive(mk(0, 0, 0, 0, 1, 0, 1, 0), 1, rb(), rb(), 9'($urandom), 1);
    m_pc     = START_PC;
    m_cnt    = '0;
    m_ir     = '0;
    m_halted = 1'b0;
    check("reset mid-mem dmem_re", dmem_re, 0);
    check("reset mid-mem busy", busy, 0);
    check("reset mid-mem pc", imem_addr, 0);
    check("reset mid-mem instr_count", instr_count, 0);
    idle_cycle();

    do_start();
    for (int n = 0; n < 300; n++) begin
      if (m_halted) begin
        repeat ($urandom_range(1, 3)) idle_cycle();
        do_start();
      end
      w = 9'($urandom);
      if (m_pc < 10'd64 && $urandom_range(0, 7) == 0) w = {3'b111, m_pc[5:0]};
      run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    if (m_halted) begin
      idle_cycle();
      do_start();
    end
    wrapped = 1'b0;
    guard   = 0;
    while (!wrapped && guard < 1100) begin
      w   = {3'($urandom_range(0, 6)), 6'($urandom)};
      pre = m_pc;
      run_instr(w, 0, 0);
      if (pre == 10'h3FF) begin
        check("pc wrap", imem_addr, 0);
        wrapped = 1'b1;
      end
      guard++;
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
